// File: rtl/axi_wr_cmd_queue_if.sv
// Producer request channel and master_axi command/response channel of the write-command queue.
// slave = the queue itself, master = the producer/master_axi side.
interface axi_wr_cmd_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  wr_done;
  logic [1:0]            wr_resp;

  modport slave (
    input  req_valid, req_addr, req_data, cmd_ready, wr_done, wr_resp,
    output req_ready, awaddr, data_in, cmd_valid
  );

  modport master (
    output req_valid, req_addr, req_data, cmd_ready, wr_done, wr_resp,
    input  req_ready, awaddr, data_in, cmd_valid
  );
endinterface

// File: rtl/axi_wr_cmd_queue.sv
// Buffers producer write requests in a FIFO and issues them one at a time to master_axi,
// holding each until its B response. Optional WAIT_B timeout: AXI_WR_CMD_QUEUE_TIMEOUT_EN.
module axi_wr_cmd_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_wr_cmd_queue_if.slave     bus,
  output logic                  busy,
  output logic [7:0]            err_count
`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
  , output logic                timeout_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B} state_e;

  state_e                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  push, pop, err_inc;

`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
`endif

  assign bus.req_ready = (count < (PTR_W+1)'(DEPTH));
  assign bus.cmd_valid = (state == ISSUE);
  assign push          = bus.req_valid && bus.req_ready;
  assign busy          = (state != IDLE) || (count != '0);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    err_inc   = 1'b0;
`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
    tmo_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmd_ready) state_nxt = WAIT_B;
      end
      WAIT_B: begin
        if (bus.wr_done) begin
          err_inc   = (bus.wr_resp != 2'b00);
          state_nxt = IDLE;
        end
`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit   = 1'b1;
          err_inc   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge aclk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.req_addr;
      data_mem[wr_ptr] <= bus.req_data;
    end
  end

  // Command registers change only on pop, so they keep the last command after completion.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bus.awaddr  <= '0;
      bus.data_in <= '0;
    end else if (pop) begin
      bus.awaddr  <= addr_mem[rd_ptr];
      bus.data_in <= data_mem[rd_ptr];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)                             err_count <= 8'h00;
    else if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

`ifdef AXI_WR_CMD_QUEUE_TIMEOUT_EN
  // Holding the counter at zero outside WAIT_B clears it on every entry.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT_B) tmo_cnt <= '0;
      else                 tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`endif

endmodule
